daq_frame_sequencer: RTL and testbench

- Timing controller for the DAQ pixel-bus datapath (sensor-emulation / capture path).
- Sequences frame_valid, line_valid and a per-pixel strobe on a divided pixel-clock tick, from runtime geometry and blanking config.
- Accepts start / single-shot / stop commands from the Wi-Fi-side control logic.
- Consumers (pattern generator, capture FIFO) advance one pixel per pix_strobe.

---
 rtl/daq_frame_sequencer.sv | 206 ++++++++++++++++++++
 tb/tb_daq_frame_sequencer.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/daq_frame_sequencer.sv
// daq_frame_sequencer: frame/line/pixel timing for the DAQ pixel-bus path.
// A free-running divider produces pix_tick; the FSM advances only on ticks and
// emits frame_valid / line_valid / pix_strobe from latched geometry.
//
// state        | meaning
// -------------+-----------------------------------------------------------
// S_IDLE       | waiting for cmd_start / cmd_single, all envelopes low
// S_ARM        | command accepted, waiting for the next pixel tick
// S_FV_LEAD    | frame_valid high, FV_LEAD ticks before the first line
// S_LINE_ACT   | line_valid high, one pix_strobe per tick
// S_LINE_BLANK | between lines, h_blank ticks
// S_FRAME_BLANK| after the last line, v_blank ticks, then next frame or idle
module daq_frame_sequencer #(
  parameter int CLK_DIV = 25,
  parameter int FV_LEAD = 2,
  parameter int HW      = 12,
  parameter int VW      = 12
) (
  input  logic          sys_clk,
  input  logic          sys_rst,
  input  logic          cmd_start,
  input  logic          cmd_single,
  input  logic          cmd_stop,
  input  logic [HW-1:0] cfg_h_active,
  input  logic [HW-1:0] cfg_h_blank,
  input  logic [VW-1:0] cfg_v_active,
  input  logic [HW-1:0] cfg_v_blank,
  output logic          frame_valid,
  output logic          line_valid,
  output logic          pix_strobe,
  output logic [HW-1:0] pix_cnt,
  output logic [VW-1:0] line_cnt,
  output logic [15:0]   frame_cnt,
  output logic          frame_done,
  output logic          busy
);

  localparam int DW = $clog2(CLK_DIV);
  localparam int LW = (FV_LEAD > 1) ? $clog2(FV_LEAD) : 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_FV_LEAD,
    S_LINE_ACT,
    S_LINE_BLANK,
    S_FRAME_BLANK
  } state_t;

  state_t        state;
  logic [DW-1:0] div_cnt;
  logic          pix_tick;
  logic [LW-1:0] lead_cnt;
  logic [HW-1:0] blank_cnt;
  logic          continuous;
  logic          stop_pending;

  logic [HW-1:0] h_act_r, h_blk_r, v_blk_r;
  logic [VW-1:0] v_act_r;
  logic [HW-1:0] h_act_c, h_blk_c, v_blk_c;
  logic [VW-1:0] v_act_c;

  assign pix_tick = (div_cnt == DW'(CLK_DIV - 1));

  // Geometry as it would be latched: zero means one tick / one unit.
  always_comb begin
    h_act_c = (cfg_h_active == '0) ? HW'(1) : cfg_h_active;
    h_blk_c = (cfg_h_blank  == '0) ? HW'(1) : cfg_h_blank;
    v_act_c = (cfg_v_active == '0) ? VW'(1) : cfg_v_active;
    v_blk_c = (cfg_v_blank  == '0) ? HW'(1) : cfg_v_blank;
  end

  // Free-running pixel-tick divider.
  always_ff @(posedge sys_clk) begin
    if (sys_rst || pix_tick) div_cnt <= '0;
    else                     div_cnt <= div_cnt + 1'b1;
  end

  // Sequencer FSM with registered outputs.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      state        <= S_IDLE;
      continuous   <= 1'b0;
      stop_pending <= 1'b0;
      lead_cnt     <= '0;
      blank_cnt    <= '0;
      h_act_r      <= '0;
      h_blk_r      <= '0;
      v_act_r      <= '0;
      v_blk_r      <= '0;
      frame_valid  <= 1'b0;
      line_valid   <= 1'b0;
      pix_strobe   <= 1'b0;
      pix_cnt      <= '0;
      line_cnt     <= '0;
      frame_cnt    <= '0;
      frame_done   <= 1'b0;
      busy         <= 1'b0;
    end else begin
      pix_strobe <= 1'b0;
      frame_done <= 1'b0;
      // Stop requests during a frame are deferred to the frame boundary.
      if (cmd_stop && state != S_IDLE && state != S_ARM) stop_pending <= 1'b1;
      case (state)
        S_IDLE: begin
          if (!cmd_stop && (cmd_start || cmd_single)) begin
            state        <= S_ARM;
            busy         <= 1'b1;
            continuous   <= cmd_start;
            stop_pending <= 1'b0;
          end
        end
        S_ARM: begin
          if (cmd_stop) begin
            state <= S_IDLE;
            busy  <= 1'b0;
          end else if (pix_tick) begin
            state       <= S_FV_LEAD;
            frame_valid <= 1'b1;
            lead_cnt    <= '0;
            h_act_r     <= h_act_c;
            h_blk_r     <= h_blk_c;
            v_act_r     <= v_act_c;
            v_blk_r     <= v_blk_c;
          end
        end
        S_FV_LEAD: begin
          if (pix_tick) begin
            if (lead_cnt == LW'(FV_LEAD - 1)) begin
              state      <= S_LINE_ACT;
              line_valid <= 1'b1;
              pix_strobe <= 1'b1;
              pix_cnt    <= '0;
              line_cnt   <= '0;
            end else begin
              lead_cnt <= lead_cnt + 1'b1;
            end
          end
        end
        S_LINE_ACT: begin
          // Strobe for pixel 0 is issued on entry; each further tick either
          // shows the next pixel or closes the line after the last one.
          if (pix_tick) begin
            if (pix_cnt == h_act_r - HW'(1)) begin
              line_valid <= 1'b0;
              if (line_cnt == v_act_r - VW'(1)) begin
                state       <= S_FRAME_BLANK;
                frame_valid <= 1'b0;
                frame_done  <= 1'b1;
                frame_cnt   <= frame_cnt + 1'b1;
                blank_cnt   <= v_blk_r - HW'(1);
              end else begin
                state     <= S_LINE_BLANK;
                blank_cnt <= h_blk_r - HW'(1);
              end
            end else begin
              pix_cnt    <= pix_cnt + 1'b1;
              pix_strobe <= 1'b1;
            end
          end
        end
        S_LINE_BLANK: begin
          if (pix_tick) begin
            if (blank_cnt == '0) begin
              state      <= S_LINE_ACT;
              line_valid <= 1'b1;
              pix_strobe <= 1'b1;
              pix_cnt    <= '0;
              line_cnt   <= line_cnt + 1'b1;
            end else begin
              blank_cnt <= blank_cnt - 1'b1;
            end
          end
        end
        S_FRAME_BLANK: begin
          if (pix_tick) begin
            if (blank_cnt == '0) begin
              if (continuous && !stop_pending && !cmd_stop) begin
                state       <= S_FV_LEAD;
                frame_valid <= 1'b1;
                lead_cnt    <= '0;
                h_act_r     <= h_act_c;
                h_blk_r     <= h_blk_c;
                v_act_r     <= v_act_c;
                v_blk_r     <= v_blk_c;
              end else begin
                state        <= S_IDLE;
                busy         <= 1'b0;
                stop_pending <= 1'b0;
              end
            end else begin
              blank_cnt <= blank_cnt - 1'b1;
            end
          end
        end
        default: begin
          state       <= S_IDLE;
          busy        <= 1'b0;
          frame_valid <= 1'b0;
          line_valid  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_daq_frame_sequencer.sv
// Self-checking bench for daq_frame_sequencer: a negedge monitor condenses the
// outputs into per-frame records, which are compared against frame geometry
// computed arithmetically from the configuration.
`timescale 1ns/1ps
module tb_daq_frame_sequencer;
  localparam int CLK_DIV = 4;
  localparam int FV_LEAD = 2;
  localparam int HW = 12;
  localparam int VW = 12;

  logic          sys_clk = 1'b0;
  logic          sys_rst = 1'b1;
  logic          cmd_start = 1'b0, cmd_single = 1'b0, cmd_stop = 1'b0;
  logic [HW-1:0] cfg_h_active = '0, cfg_h_blank = '0, cfg_v_blank = '0;
  logic [VW-1:0] cfg_v_active = '0;
  logic          frame_valid, line_valid, pix_strobe, frame_done, busy;
  logic [HW-1:0] pix_cnt;
  logic [VW-1:0] line_cnt;
  logic [15:0]   frame_cnt;

  daq_frame_sequencer #(.CLK_DIV(CLK_DIV), .FV_LEAD(FV_LEAD), .HW(HW), .VW(VW)) dut (
    .sys_clk(sys_clk), .sys_rst(sys_rst),
    .cmd_start(cmd_start), .cmd_single(cmd_single), .cmd_stop(cmd_stop),
    .cfg_h_active(cfg_h_active), .cfg_h_blank(cfg_h_blank),
    .cfg_v_active(cfg_v_active), .cfg_v_blank(cfg_v_blank),
    .frame_valid(frame_valid), .line_valid(line_valid), .pix_strobe(pix_strobe),
    .pix_cnt(pix_cnt), .line_cnt(line_cnt), .frame_cnt(frame_cnt),
    .frame_done(frame_done), .busy(busy)
  );

  always #5 sys_clk = ~sys_clk;

  int n_checks = 0;
  int n_fail = 0;
  logic [15:0] exp_frames = '0;

  task automatic chk(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  // Per-frame records gathered by the monitor.
  int rise_t[$], fall_t[$], fr_strobes[$], fr_lines[$], fr_lmin[$], fr_lmax[$];
  int cyc = 0, busy_fall_t = -1, done_cnt = 0, seq_err = 0, inv_err = 0, busy_hi = 0;
  int cur_strobes = 0, cur_lines = 0, cur_ls = 0, exp_pix = 0, exp_line = 0;
  int lmin = 0, lmax = 0;
  logic p_fv = 1'b0, p_lv = 1'b0, p_busy = 1'b0;

  initial begin
    forever begin
      @(negedge sys_clk);
      cyc++;
      if (busy) busy_hi++;
      if (!sys_rst) begin
        if (line_valid && !frame_valid) inv_err++;
        if (pix_strobe && !line_valid) inv_err++;
        if (frame_valid && !p_fv) begin
          rise_t.push_back(cyc);
          cur_strobes = 0; cur_lines = 0; exp_line = 0; lmin = 1 << 30; lmax = 0;
        end
        if (line_valid && !p_lv) begin
          cur_ls = 0; exp_pix = 0; cur_lines++;
        end
        if (pix_strobe) begin
          if (int'(pix_cnt) != exp_pix || int'(line_cnt) != exp_line) seq_err++;
          exp_pix++; cur_ls++; cur_strobes++;
        end
        if (!line_valid && p_lv) begin
          if (cur_ls < lmin) lmin = cur_ls;
          if (cur_ls > lmax) lmax = cur_ls;
          exp_line++;
        end
        if (!frame_valid && p_fv) begin
          fall_t.push_back(cyc);
          fr_strobes.push_back(cur_strobes);
          fr_lines.push_back(cur_lines);
          fr_lmin.push_back(lmin);
          fr_lmax.push_back(lmax);
          if (!frame_done) seq_err++;
        end
        if (frame_done) begin
          done_cnt++;
          if (!(p_fv && !frame_valid)) seq_err++;
        end
        if (!busy && p_busy) busy_fall_t = cyc;
      end
      p_fv = frame_valid; p_lv = line_valid; p_busy = busy;
    end
  end

  initial begin
    #800000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic int clamp(input int v);
    return (v == 0) ? 1 : v;
  endfunction

  task automatic clear_stats();
    rise_t.delete(); fall_t.delete(); fr_strobes.delete(); fr_lines.delete();
    fr_lmin.delete(); fr_lmax.delete();
    busy_fall_t = -1; done_cnt = 0; busy_hi = 0;
  endtask

  task automatic check_errs(input string tag);
    chk({tag, " envelope nesting"}, inv_err, 0);
    chk({tag, " pixel/line index"}, seq_err, 0);
    inv_err = 0; seq_err = 0;
  endtask

  task automatic set_cfg(input int ha, input int hb, input int va, input int vb);
    cfg_h_active = HW'(ha); cfg_h_blank = HW'(hb);
    cfg_v_active = VW'(va); cfg_v_blank = HW'(vb);
  endtask

  task automatic pulse(input int which);
    @(posedge sys_clk); #2;
    case (which)
      0: cmd_start = 1'b1;
      1: cmd_single = 1'b1;
      default: cmd_stop = 1'b1;
    endcase
    @(posedge sys_clk); #2;
    cmd_start = 1'b0; cmd_single = 1'b0; cmd_stop = 1'b0;
  endtask

  task automatic wait_idle(input string tag);
    int n = 0;
    while (busy && n < 5000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    chk({tag, " reaches idle"}, int'(n < 5000), 1);
  endtask

  task automatic check_frame(input string tag, input int idx, input int ha_i, input int hb_i,
                             input int va_i, input int vb_i, input int end_t);
    int ha = clamp(ha_i), hb = clamp(hb_i), va = clamp(va_i), vb = clamp(vb_i);
    int fv_ticks = FV_LEAD + va * ha + (va - 1) * hb;
    if (idx >= fall_t.size()) begin
      chk({tag, " frame present"}, fall_t.size(), idx + 1);
      return;
    end
    chk({tag, " strobes"}, fr_strobes[idx], va * ha);
    chk({tag, " lines"}, fr_lines[idx], va);
    chk({tag, " min strobes/line"}, fr_lmin[idx], ha);
    chk({tag, " max strobes/line"}, fr_lmax[idx], ha);
    chk({tag, " frame_valid clks"}, fall_t[idx] - rise_t[idx], fv_ticks * CLK_DIV);
    chk({tag, " frame length clks"}, end_t - rise_t[idx], (fv_ticks + vb) * CLK_DIV);
  endtask

  task automatic run_single(input string tag, input int ha, input int hb, input int va,
                            input int vb, input int pre);
    set_cfg(ha, hb, va, vb);
    clear_stats();
    repeat (pre) @(posedge sys_clk);
    pulse(1);
    wait_idle(tag);
    chk({tag, " frame count"}, rise_t.size(), 1);
    chk({tag, " frame_done pulses"}, done_cnt, 1);
    check_frame(tag, 0, ha, hb, va, vb, busy_fall_t);
    exp_frames = exp_frames + 16'd1;
    chk({tag, " frame_cnt"}, int'(frame_cnt), int'(exp_frames));
    check_errs(tag);
  endtask

  initial begin
    int n;
    // Reset state.
    repeat (3) @(posedge sys_clk);
    @(negedge sys_clk); #1;
    chk("rst frame_valid", int'(frame_valid), 0);
    chk("rst line_valid", int'(line_valid), 0);
    chk("rst pix_strobe", int'(pix_strobe), 0);
    chk("rst pix_cnt", int'(pix_cnt), 0);
    chk("rst line_cnt", int'(line_cnt), 0);
    chk("rst frame_cnt", int'(frame_cnt), 0);
    chk("rst frame_done", int'(frame_done), 0);
    chk("rst busy", int'(busy), 0);
    @(posedge sys_clk); #2;
    sys_rst = 1'b0;

    // Reference geometry: 18 ticks of frame_valid, 23 ticks total.
    run_single("geom", 4, 2, 3, 5, 0);
    // Zero blanking/active values clamp to one.
    run_single("clamp", 2, 0, 2, 0, 1);
    run_single("clamp0", 0, 0, 0, 0, 2);

    for (int i = 0; i < 8; i++)
      run_single("rnd", $urandom_range(0, 6), $urandom_range(0, 3), $urandom_range(0, 4),
                 $urandom_range(0, 4), $urandom_range(0, 7));

    // Continuous run, stop in line 1 of frame 2: frame 2 completes, no frame 3.
    set_cfg(3, 1, 3, 2);
    clear_stats();
    pulse(0);
    n = 0;
    while (!(rise_t.size() == 2 && line_valid && line_cnt == VW'(1)) && n < 5000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    chk("stop reach frame2 line1", int'(n < 5000), 1);
    pulse(2);
    wait_idle("stop");
    repeat (200) @(negedge sys_clk);
    #1;
    chk("stop frame rises", rise_t.size(), 2);
    chk("stop frame_done pulses", done_cnt, 2);
    check_frame("stop f1", 0, 3, 1, 3, 2, rise_t[1]);
    check_frame("stop f2", 1, 3, 1, 3, 2, busy_fall_t);
    exp_frames = exp_frames + 16'd2;
    chk("stop frame_cnt", int'(frame_cnt), int'(exp_frames));
    check_errs("stop");

    // Config change mid-frame only takes effect at the next frame.
    set_cfg(4, 1, 2, 1);
    clear_stats();
    pulse(0);
    n = 0;
    while (!(rise_t.size() == 1 && pix_strobe) && n < 5000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    chk("cfgchg reach frame1", int'(n < 5000), 1);
    cfg_h_active = HW'(6);
    n = 0;
    while (rise_t.size() < 2 && n < 5000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    chk("cfgchg reach frame2", int'(n < 5000), 1);
    pulse(2);
    wait_idle("cfgchg");
    chk("cfgchg frame rises", rise_t.size(), 2);
    check_frame("cfgchg f1", 0, 4, 1, 2, 1, rise_t[1]);
    check_frame("cfgchg f2", 1, 6, 1, 2, 1, busy_fall_t);
    exp_frames = exp_frames + 16'd2;
    chk("cfgchg frame_cnt", int'(frame_cnt), int'(exp_frames));
    check_errs("cfgchg");

    // Stop wins over a simultaneous start or single in IDLE.
    clear_stats();
    @(posedge sys_clk); #2;
    cmd_start = 1'b1; cmd_stop = 1'b1;
    @(posedge sys_clk); #2;
    cmd_start = 1'b0; cmd_stop = 1'b0;
    repeat (40) @(negedge sys_clk);
    #1;
    chk("start+stop busy cycles", busy_hi, 0);
    clear_stats();
    @(posedge sys_clk); #2;
    cmd_single = 1'b1; cmd_stop = 1'b1;
    @(posedge sys_clk); #2;
    cmd_single = 1'b0; cmd_stop = 1'b0;
    repeat (40) @(negedge sys_clk);
    #1;
    chk("single+stop busy cycles", busy_hi, 0);

    // Stop while armed returns to IDLE without a frame.
    clear_stats();
    @(posedge sys_clk); #2;
    cmd_single = 1'b1;
    @(posedge sys_clk); #2;
    cmd_single = 1'b0; cmd_stop = 1'b1;
    @(posedge sys_clk); #2;
    cmd_stop = 1'b0;
    repeat (40) @(negedge sys_clk);
    #1;
    chk("arm stop busy cycles", busy_hi, 1);
    chk("arm stop frame rises", rise_t.size(), 0);

    // Reset during an active line.
    set_cfg(5, 1, 3, 1);
    clear_stats();
    pulse(0);
    n = 0;
    while (!(line_valid && pix_cnt == HW'(2)) && n < 5000) begin
      @(negedge sys_clk); #1;
      n++;
    end
    chk("rst-mid reach line", int'(n < 5000), 1);
    @(posedge sys_clk); #2;
    sys_rst = 1'b1;
    @(posedge sys_clk);
    @(negedge sys_clk); #1;
    chk("rst-mid frame_valid", int'(frame_valid), 0);
    chk("rst-mid line_valid", int'(line_valid), 0);
    chk("rst-mid pix_strobe", int'(pix_strobe), 0);
    chk("rst-mid pix_cnt", int'(pix_cnt), 0);
    chk("rst-mid line_cnt", int'(line_cnt), 0);
    chk("rst-mid frame_cnt", int'(frame_cnt), 0);
    chk("rst-mid busy", int'(busy), 0);
    sys_rst = 1'b0;
    exp_frames = '0;
    inv_err = 0; seq_err = 0;
    run_single("post-rst", 5, 1, 3, 1, 0);

    // frame_cnt wraps from 0xFFFF to 0.
    @(posedge sys_clk); #2;
    force dut.frame_cnt = 16'hFFFF;
    #1;
    release dut.frame_cnt;
    exp_frames = 16'hFFFF;
    run_single("wrap", 2, 1, 2, 1, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
